// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// No logic of its own; imported by mem_arbiter.
// No flow control here.
package mem_arbiter_pkg;

    // Arbiter FSM encodings: idle, serving fetch, serving load/store.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_IF   = 2'b01,
        ARB_MEM  = 2'b10
    } arb_state_e;

    localparam logic        AVAIL    = 1'b1;
    localparam logic        UNAVAIL  = 1'b0;
    localparam logic [31:0] ZEROWORD = 32'h0000_0000;
    localparam logic [3:0]  SEL_ALL  = 4'hF;

    // Bus command captured at grant and held for the whole bus cycle.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } bus_cmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory bus port between instruction fetch and load/store, MEM first.
// Latency: command on bus 1 cycle after grant; ack same cycle as bus_ack; >=1 idle cycle between transfers.
// Backpressure: requesters hold req until their ack; stall_o is raised while any request is unanswered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_err,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stall_o
);

    // Counter value seen in the last bus cycle before giving up.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    arb_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    bus_cmd_t   cmd_q, cmd_d;
    logic       bus_req_q, bus_req_d;
    logic       timed_out;

    // A timeout only counts when the slave did not answer in that same cycle.
    assign timed_out = (cnt_q == TO_LAST) && !bus_ack;

    // State, timeout counter and registered bus command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ARB_IDLE;
            cnt_q     <= 8'd0;
            cmd_q     <= '0;
            bus_req_q <= UNAVAIL;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            bus_req_q <= bus_req_d;
        end
    end

    // Grant decision, completion/timeout detection and requester responses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        bus_req_d = bus_req_q;
        if_ack    = UNAVAIL;
        if_err    = UNAVAIL;
        if_rdata  = ZEROWORD;
        mem_ack   = UNAVAIL;
        mem_err   = UNAVAIL;
        mem_rdata = ZEROWORD;

        case (state_q)
            ARB_IDLE: begin
                // Stray bus_ack is ignored here; MEM is the older instruction so it wins.
                if (mem_req) begin
                    cmd_d     = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, sel: mem_sel};
                    cnt_d     = 8'd0;
                    bus_req_d = AVAIL;
                    state_d   = ARB_MEM;
                end else if (if_req) begin
                    cmd_d     = '{we: 1'b0, addr: if_addr, wdata: ZEROWORD, sel: SEL_ALL};
                    cnt_d     = 8'd0;
                    bus_req_d = AVAIL;
                    state_d   = ARB_IF;
                end
            end
            ARB_IF: begin
                if (bus_ack || timed_out) begin
                    if_ack    = AVAIL;
                    if_err    = timed_out;
                    if_rdata  = bus_ack ? bus_rdata : ZEROWORD;
                    bus_req_d = UNAVAIL;
                    state_d   = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ARB_MEM: begin
                if (bus_ack || timed_out) begin
                    mem_ack   = AVAIL;
                    mem_err   = timed_out;
                    mem_rdata = bus_ack ? bus_rdata : ZEROWORD;
                    bus_req_d = UNAVAIL;
                    state_d   = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                bus_req_d = UNAVAIL;
                state_d   = ARB_IDLE;
            end
        endcase
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = cmd_q.we;
    assign bus_addr  = cmd_q.addr;
    assign bus_wdata = cmd_q.wdata;
    assign bus_sel   = cmd_q.sel;

    assign stall_o = (if_req & ~if_ack) | (mem_req & ~mem_ack);

endmodule
